// File: rtl/mips_shift_pkg.sv
// Shared encodings for the iterative MIPS32 shift unit: shift opcodes and FSM states.
package mips_shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// One conditional shift by 2^k; reused every cycle by the iterative shift unit.
// Rotate support is compiled in only when ITER_SHIFT_ROTATE_EN is defined.
module shift_stage
  import mips_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] k,
  input  logic               enable,
  output logic [WIDTH-1:0]   shifted
);

  // Stage weight 2^k never exceeds WIDTH/2, so it fits in SHAMT_W bits.
  logic [SHAMT_W-1:0] amt;
  assign amt = SHAMT_W'(1) << k;

`ifdef ITER_SHIFT_ROTATE_EN
  localparam logic [SHAMT_W:0] W_FULL = (SHAMT_W+1)'(WIDTH);
  logic [SHAMT_W:0] ramt;
  assign ramt = W_FULL - {1'b0, amt};
`endif

  always_comb begin
    shifted = data;
    if (enable) begin
      case (op)
        SH_SLL:  shifted = data << amt;
        SH_SRA:  shifted = $signed(data) >>> amt;
`ifdef ITER_SHIFT_ROTATE_EN
        SH_ROR:  shifted = (data >> amt) | (data << ramt);
`endif
        default: shifted = data >> amt;
      endcase
    end
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA(/ROR) unit resolving one shift-amount bit per cycle, MSB first.
// Optional rotate mode is enabled by defining ITER_SHIFT_ROTATE_EN.
module iter_shift_unit
  import mips_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_t             state;
  logic [WIDTH-1:0]   work_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [SHAMT_W-1:0] k_q;
  logic [WIDTH-1:0]   shifted;

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data    (work_q),
    .op      (op_q),
    .k       (k_q),
    .enable  (shamt_q[k_q]),
    .shifted (shifted)
  );

  // Control FSM; result and done are loaded on the edge that completes the k=0 stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      work_q  <= '0;
      op_q    <= SH_SLL;
      shamt_q <= '0;
      k_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work_q  <= data;
            op_q    <= op;
            shamt_q <= shamt;
            k_q     <= SHAMT_W'(SHAMT_W - 1);
            state   <= SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          work_q <= shifted;
          if (k_q == '0) begin
            state  <= DONE;
            result <= shifted;
            done   <= 1'b1;
          end else begin
            k_q <= k_q - SHAMT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: 32-bit and 8-bit instances, directed vectors.
module tb_iter_shift_unit;

  logic        clk;
  logic        rst_n;

  logic        start32, ready32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] data32, result32;
  logic [4:0]  shamt32;

  logic        start8, ready8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  data8, result8;
  logic [2:0]  shamt8;

  typedef struct {
    logic [31:0] val;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  iter_shift_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .data(data32),
    .shamt(shamt32), .ready(ready32), .busy(busy32), .done(done32), .result(result32)
  );

  iter_shift_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .data(data8),
    .shamt(shamt8), .ready(ready8), .busy(busy8), .done(done8), .result(result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done32) begin
      exp_t e;
      if (q32.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_done32: got done=1, expected no pending op");
      end else begin
        e = q32.pop_front();
        chk("result32", result32, e.val);
        chk("latency32", 32'(cyc - e.acc), 32'd6);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      exp_t e;
      if (q8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_done8: got done=1, expected no pending op");
      end else begin
        e = q8.pop_front();
        chk("result8", {24'h0, result8}, e.val);
        chk("latency8", 32'(cyc - e.acc), 32'd4);
      end
    end
  end

  task automatic issue(input bit sel8, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(sel8 ? ready8 : ready32) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles, expected ready=1");
      return;
    end
    e.val = exp;
    e.acc = cyc;
    if (sel8) begin
      start8 = 1'b1; op8 = o; data8 = d[7:0]; shamt8 = s[2:0];
      q8.push_back(e);
    end else begin
      start32 = 1'b1; op32 = o; data32 = d; shamt32 = s;
      q32.push_back(e);
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ror32_exp, ror8_exp;
`ifdef ITER_SHIFT_ROTATE_EN
    ror32_exp = 32'h1000_000F;
    ror8_exp  = 32'h0000_00C0;
`else
    ror32_exp = 32'h0000_000F;
    ror8_exp  = 32'h0000_0040;
`endif
    start32 = 1'b0; op32 = 2'b00; data32 = '0; shamt32 = '0;
    start8  = 1'b0; op8  = 2'b00; data8  = '0; shamt8  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready32", {31'h0, ready32}, 32'd1);
    chk("rst_busy32", {31'h0, busy32}, 32'd0);
    chk("rst_done32", {31'h0, done32}, 32'd0);
    chk("rst_result32", result32, 32'h0);
    chk("rst_ready8", {31'h0, ready8}, 32'd1);
    chk("rst_result8", {24'h0, result8}, 32'h0);
    rst_n = 1'b1;

    issue(1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    issue(1'b0, 2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000);
    issue(1'b0, 2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000);
    issue(1'b0, 2'b11, 32'h0000_00F1, 5'd4,  ror32_exp);
    issue(1'b0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    issue(1'b0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    issue(1'b0, 2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800);
    issue(1'b0, 2'b10, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF);
    issue(1'b1, 2'b10, 32'h0000_0080, 5'd7,  32'h0000_00FF);
    issue(1'b1, 2'b00, 32'h0000_0081, 5'd1,  32'h0000_0002);
    issue(1'b1, 2'b11, 32'h0000_0081, 5'd1,  ror8_exp);
    issue(1'b0, 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    drain();

    // Result must hold while idle.
    repeat (3) @(negedge clk);
    chk("hold_result32", result32, 32'hDEAD_BEEF);
    chk("hold_ready32", {31'h0, ready32}, 32'd1);

    // Start held high for 21 edges: accepts every 7 cycles, exactly three ops.
    e.val = 32'h0000_0006;
    e.acc = cyc;      q32.push_back(e);
    e.acc = cyc + 7;  q32.push_back(e);
    e.acc = cyc + 14; q32.push_back(e);
    start32 = 1'b1; op32 = 2'b00; data32 = 32'h0000_0003; shamt32 = 5'd1;
    repeat (21) @(negedge clk);
    start32 = 1'b0;
    drain();

    // Reset mid-operation: no done, outputs back to reset values.
    start32 = 1'b1; op32 = 2'b00; data32 = 32'h0000_0001; shamt32 = 5'd8;
    @(negedge clk);
    start32 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready32", {31'h0, ready32}, 32'd1);
    chk("midrst_busy32", {31'h0, busy32}, 32'd0);
    chk("midrst_done32", {31'h0, done32}, 32'd0);
    chk("midrst_result32", result32, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("postrst_result32", result32, 32'h0);
    issue(1'b0, 2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
